// File: rtl/multi_sprite_engine_if.sv
// Register write port from the config writer (SPI receiver) into the sprite engine.
//
// Signals:
//   wr_en    register write strobe, one cycle per write
//   wr_addr  {sprite index, 5-bit register offset}
//   wr_data  16-bit write data
//
// Modports:
//   master   config writer side (drives the port)
//   slave    sprite engine side (samples the port)
interface multi_sprite_engine_if #(
    parameter int ADDR_W = 7
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/multi_sprite_engine.sv
// Multi-sprite renderer. Draws NUM_SPRITES independent 1-bpp sprites over the
// downscaled raster and outputs the winning (lowest-index) opaque pixel two
// clocks after the raster counters, plus per-frame collision flags. Sprites
// can optionally bounce around the visible area, stepping once per frame.
//
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   counter_h/v   signed raster counters, negative during blanking
//   blank         hblank or vblank
//   next_frame    one-cycle pulse at frame end (movement + collision latch)
//   cfg           register write port (slave side)
//   sprite_hit    opaque sprite pixel present (registered)
//   sprite_color  rrggbb of winning sprite (registered)
//   sprite_id     index of winning sprite (registered)
//   collision     per-sprite collision flags of the previous frame
//
// Register offsets per sprite: 0 CTRL {move, enable}, 1 X, 2 Y, 3 COLOR,
// 16+r bitmap row r (MSB = leftmost column).
module multi_sprite_engine #(
    parameter int NUM_SPRITES   = 4,
    parameter int SPRITE_WIDTH  = 12,
    parameter int SPRITE_HEIGHT = 12,
    parameter int SCALE_LOG2    = 3,
    parameter int CNT_W         = 11,
    parameter int WIDTH_SMALL   = 100,
    parameter int HEIGHT_SMALL  = 75,
    localparam int ID_W         = $clog2(NUM_SPRITES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [CNT_W-1:0] counter_h,
    input  logic signed [CNT_W-1:0] counter_v,
    input  logic                    blank,
    input  logic                    next_frame,
    multi_sprite_engine_if.slave    cfg,
    output logic                    sprite_hit,
    output logic [5:0]              sprite_color,
    output logic [ID_W-1:0]         sprite_id,
    output logic [NUM_SPRITES-1:0]  collision
);

    localparam logic [7:0] X_MAX = 8'(WIDTH_SMALL - SPRITE_WIDTH);
    localparam logic [7:0] Y_MAX = 8'(HEIGHT_SMALL - SPRITE_HEIGHT);

    // Per-sprite state
    logic                    en     [NUM_SPRITES];
    logic                    mv     [NUM_SPRITES];
    logic [7:0]              pos_x  [NUM_SPRITES];
    logic [7:0]              pos_y  [NUM_SPRITES];
    logic                    neg_x  [NUM_SPRITES];   // 1 = moving toward 0
    logic                    neg_y  [NUM_SPRITES];
    logic [5:0]              color  [NUM_SPRITES];
    logic [SPRITE_WIDTH-1:0] bitmap [NUM_SPRITES][SPRITE_HEIGHT];

    // Write decode
    logic [ID_W-1:0]        wr_idx;
    logic [4:0]             wr_off;
    logic [NUM_SPRITES-1:0] sel;

    assign wr_idx = cfg.wr_addr[ID_W+4:5];
    assign wr_off = cfg.wr_addr[4:0];

    // Downscaled raster position
    logic signed [CNT_W-1:0] cx_s;
    logic signed [CNT_W-1:0] cy_s;
    logic [8:0]              cx;
    logic [8:0]              cy;
    logic                    on_raster;

    assign cx_s      = counter_h >>> SCALE_LOG2;
    assign cy_s      = counter_v >>> SCALE_LOG2;
    assign cx        = cx_s[8:0];
    assign cy        = cy_s[8:0];
    assign on_raster = !cx_s[CNT_W-1] && !cy_s[CNT_W-1];

    logic [NUM_SPRITES-1:0] opaque;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_sprite
        logic [8:0]              x9, y9, dx, dy;
        logic                    in_x, in_y;
        logic [SPRITE_WIDTH-1:0] row;

        assign sel[g] = cfg.wr_en && (wr_idx == ID_W'(g));

        // 9-bit compares so x+SPRITE_WIDTH never wraps past 255
        assign x9   = {1'b0, pos_x[g]};
        assign y9   = {1'b0, pos_y[g]};
        assign dx   = cx - x9;
        assign dy   = cy - y9;
        assign in_x = (cx >= x9) && (cx < x9 + 9'(SPRITE_WIDTH));
        assign in_y = (cy >= y9) && (cy < y9 + 9'(SPRITE_HEIGHT));
        assign row  = bitmap[g][dy[3:0]];

        assign opaque[g] = en[g] && on_raster && in_x && in_y
                           && row[4'(SPRITE_WIDTH - 1) - dx[3:0]];
    end

    // Configuration registers and per-frame movement
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                en[i]    <= 1'b0;
                mv[i]    <= 1'b0;
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                neg_x[i] <= 1'b0;
                neg_y[i] <= 1'b0;
                color[i] <= '0;
                for (int r = 0; r < SPRITE_HEIGHT; r++) begin
                    bitmap[i][r] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (sel[i] && wr_off == 5'd0) begin
                    en[i] <= cfg.wr_data[0];
                    mv[i] <= cfg.wr_data[1];
                end
                if (sel[i] && wr_off == 5'd3) begin
                    color[i] <= cfg.wr_data[5:0];
                end
                for (int r = 0; r < SPRITE_HEIGHT; r++) begin
                    if (sel[i] && wr_off == 5'(16 + r)) begin
                        bitmap[i][r] <= cfg.wr_data[SPRITE_WIDTH-1:0];
                    end
                end

                // A CPU write to X/Y overrides the movement step; direction kept.
                if (sel[i] && wr_off == 5'd1) begin
                    pos_x[i] <= cfg.wr_data[7:0];
                end else if (next_frame && en[i] && mv[i]) begin
                    if (!neg_x[i]) begin
                        if (pos_x[i] >= X_MAX) begin
                            neg_x[i] <= 1'b1;
                            pos_x[i] <= (pos_x[i] == X_MAX) ? X_MAX - 8'd1 : X_MAX;
                        end else begin
                            pos_x[i] <= pos_x[i] + 8'd1;
                        end
                    end else begin
                        if (pos_x[i] == 8'd0) begin
                            neg_x[i] <= 1'b0;
                            pos_x[i] <= 8'd1;
                        end else if (pos_x[i] > X_MAX) begin
                            pos_x[i] <= X_MAX;
                        end else begin
                            pos_x[i] <= pos_x[i] - 8'd1;
                        end
                    end
                end

                if (sel[i] && wr_off == 5'd2) begin
                    pos_y[i] <= cfg.wr_data[7:0];
                end else if (next_frame && en[i] && mv[i]) begin
                    if (!neg_y[i]) begin
                        if (pos_y[i] >= Y_MAX) begin
                            neg_y[i] <= 1'b1;
                            pos_y[i] <= (pos_y[i] == Y_MAX) ? Y_MAX - 8'd1 : Y_MAX;
                        end else begin
                            pos_y[i] <= pos_y[i] + 8'd1;
                        end
                    end else begin
                        if (pos_y[i] == 8'd0) begin
                            neg_y[i] <= 1'b0;
                            pos_y[i] <= 8'd1;
                        end else if (pos_y[i] > Y_MAX) begin
                            pos_y[i] <= Y_MAX;
                        end else begin
                            pos_y[i] <= pos_y[i] - 8'd1;
                        end
                    end
                end
            end
        end
    end

    // Stage 1: opaque vector and blank
    logic [NUM_SPRITES-1:0] opaque_q;
    logic                   blank_q;
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_now;

    // Two or more opaque bits <=> clearing the lowest set bit leaves something.
    assign coll_now = (!blank_q && ((opaque_q & (opaque_q - 1'b1)) != '0))
                      ? opaque_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            opaque_q  <= '0;
            blank_q   <= 1'b0;
            coll_acc  <= '0;
            collision <= '0;
        end else begin
            opaque_q <= opaque;
            blank_q  <= blank;
            if (next_frame) begin
                collision <= coll_acc | coll_now;
                coll_acc  <= '0;
            end else begin
                coll_acc <= coll_acc | coll_now;
            end
        end
    end

    // Stage 2: priority encode, lowest index wins
    logic            win_hit;
    logic [ID_W-1:0] win_id;
    logic [5:0]      win_color;

    always_comb begin
        win_hit   = 1'b0;
        win_id    = '0;
        win_color = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque_q[i]) begin
                win_hit   = 1'b1;
                win_id    = ID_W'(i);
                win_color = color[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || blank_q) begin
            sprite_hit   <= 1'b0;
            sprite_color <= '0;
            sprite_id    <= '0;
        end else begin
            sprite_hit   <= win_hit;
            sprite_color <= win_color;
            sprite_id    <= win_id;
        end
    end

endmodule

// File: tb/tb_multi_sprite_engine.sv
// Directed bench for multi_sprite_engine: latency, priority, row/column
// addressing, collision latching, bounce movement, write/step conflict,
// blanking and reset behaviour. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_multi_sprite_engine;

    localparam int ADDR_W = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [10:0] counter_h;
    logic signed [10:0] counter_v;
    logic               blank;
    logic               next_frame;
    logic               sprite_hit;
    logic [5:0]         sprite_color;
    logic [1:0]         sprite_id;
    logic [3:0]         collision;

    int tests_run    = 0;
    int tests_failed = 0;

    multi_sprite_engine_if #(.ADDR_W(ADDR_W)) cfg ();

    multi_sprite_engine dut (
        .clk          (clk),
        .reset        (reset),
        .counter_h    (counter_h),
        .counter_v    (counter_v),
        .blank        (blank),
        .next_frame   (next_frame),
        .cfg          (cfg),
        .sprite_hit   (sprite_hit),
        .sprite_color (sprite_color),
        .sprite_id    (sprite_id),
        .collision    (collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int spr, input int off, input logic [15:0] data);
        @(negedge clk);
        cfg.wr_en   = 1'b1;
        cfg.wr_addr = ADDR_W'(spr * 32 + off);
        cfg.wr_data = data;
        @(negedge clk);
        cfg.wr_en   = 1'b0;
    endtask

    task automatic raster(input int x, input int y, input logic b);
        @(negedge clk);
        counter_h = 11'(x * 8);
        counter_v = 11'(y * 8);
        blank     = b;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
    endtask

    task automatic chk_pix(input string tag, input logic hit, input logic [5:0] col,
                           input logic [1:0] id);
        chk({tag, "_hit"}, 16'(sprite_hit), 16'(hit));
        chk({tag, "_color"}, 16'(sprite_color), 16'(col));
        chk({tag, "_id"}, 16'(sprite_id), 16'(id));
    endtask

    initial begin
        reset       = 1'b1;
        counter_h   = '0;
        counter_v   = '0;
        blank       = 1'b0;
        next_frame  = 1'b0;
        cfg.wr_en   = 1'b0;
        cfg.wr_addr = '0;
        cfg.wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk_pix("reset", 1'b0, 6'h00, 2'd0);
        chk("reset_coll", 16'(collision), 16'h0);

        // Sprite 0 at (10,5), leftmost column of row 0 opaque
        wr(0, 1, 16'd10);
        wr(0, 2, 16'd5);
        wr(0, 16, 16'h800);
        wr(0, 3, 16'h31);
        wr(0, 0, 16'h1);
        raster(0, 0, 1'b0);
        settle();
        chk("empty_hit", 16'(sprite_hit), 16'h0);

        raster(10, 5, 1'b0);
        @(negedge clk);
        chk("lat1_hit", 16'(sprite_hit), 16'h0);
        @(negedge clk);
        chk_pix("lat2", 1'b1, 6'h31, 2'd0);

        raster(11, 5, 1'b0);
        settle();
        chk("cx11_hit", 16'(sprite_hit), 16'h0);

        // Row 3, rightmost column -> pixel (21,8); (22,8) is past the sprite
        wr(0, 19, 16'h001);
        raster(21, 8, 1'b0);
        settle();
        chk_pix("row3_right", 1'b1, 6'h31, 2'd0);
        raster(22, 8, 1'b0);
        settle();
        chk("row3_past_hit", 16'(sprite_hit), 16'h0);

        // Sprites 0 and 2 overlap at (10,5)
        wr(0, 3, 16'h0C);
        wr(2, 1, 16'd10);
        wr(2, 2, 16'd5);
        wr(2, 16, 16'h800);
        wr(2, 3, 16'h30);
        wr(2, 0, 16'h1);
        raster(10, 5, 1'b0);
        settle();
        chk_pix("prio", 1'b1, 6'h0C, 2'd0);
        raster(50, 50, 1'b0);
        settle();
        frame();
        chk("coll_set", 16'(collision), 16'h5);
        frame();
        chk("coll_clear", 16'(collision), 16'h0);

        // Sprite 1 bouncing from (87,62), direction +1/+1
        wr(0, 0, 16'h0);
        wr(2, 0, 16'h0);
        wr(1, 1, 16'd87);
        wr(1, 2, 16'd62);
        wr(1, 16, 16'h800);
        wr(1, 3, 16'h15);
        wr(1, 0, 16'h3);
        frame();
        raster(88, 63, 1'b0);
        settle();
        chk_pix("move_f1", 1'b1, 6'h15, 2'd1);
        raster(87, 63, 1'b0);
        settle();
        chk("move_f1_left_hit", 16'(sprite_hit), 16'h0);
        frame();
        raster(87, 62, 1'b0);
        settle();
        chk_pix("bounce_f2", 1'b1, 6'h15, 2'd1);
        raster(88, 62, 1'b0);
        settle();
        chk("bounce_f2_old_hit", 16'(sprite_hit), 16'h0);

        // X write coinciding with next_frame: written value held, y still steps
        @(negedge clk);
        cfg.wr_en   = 1'b1;
        cfg.wr_addr = ADDR_W'(1 * 32 + 1);
        cfg.wr_data = 16'd40;
        next_frame  = 1'b1;
        @(negedge clk);
        cfg.wr_en   = 1'b0;
        next_frame  = 1'b0;
        raster(40, 61, 1'b0);
        settle();
        chk_pix("wr_vs_step", 1'b1, 6'h15, 2'd1);
        frame();
        raster(39, 60, 1'b0);
        settle();
        chk_pix("dir_kept", 1'b1, 6'h15, 2'd1);
        raster(40, 60, 1'b0);
        settle();
        chk("dir_kept_old_hit", 16'(sprite_hit), 16'h0);
        chk("single_coll", 16'(collision), 16'h0);

        // Sprite 3 at origin: negative counter, blank, empty bitmap
        wr(3, 1, 16'd0);
        wr(3, 2, 16'd0);
        wr(3, 16, 16'h800);
        wr(3, 3, 16'h3F);
        wr(3, 0, 16'h1);
        raster(0, 0, 1'b0);
        settle();
        chk_pix("origin", 1'b1, 6'h3F, 2'd3);
        @(negedge clk);
        counter_h = -11'sd1;
        counter_v = 11'sd0;
        settle();
        chk("neg_h_hit", 16'(sprite_hit), 16'h0);
        raster(0, 0, 1'b1);
        settle();
        chk_pix("blank", 1'b0, 6'h00, 2'd0);
        wr(3, 16, 16'h000);
        raster(0, 0, 1'b0);
        settle();
        chk("zero_bmp_hit", 16'(sprite_hit), 16'h0);

        // Reset mid-line while a pixel is being drawn
        wr(0, 0, 16'h1);
        raster(10, 5, 1'b0);
        settle();
        chk_pix("pre_rst", 1'b1, 6'h0C, 2'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_pix("mid_rst", 1'b0, 6'h00, 2'd0);
        chk("mid_rst_coll", 16'(collision), 16'h0);
        settle();
        chk("post_rst_hit", 16'(sprite_hit), 16'h0);
        wr(0, 0, 16'h1);
        settle();
        chk("reen_cleared_bmp_hit", 16'(sprite_hit), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
